// File: rtl/multiplier_sum_mac_pipelined.sv
// multiplier_sum_mac_pipelined: pipelined SIMD multiply / sum-of-products unit
// with running accumulator, sticky overflow and globally stalled valid/ready flow.
module multiplier_sum_mac_pipelined #(
    parameter int SUB_W = 9,
    parameter int K     = 3,
    parameter int ACC_W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K*K*SUB_W-1:0]   a,
    input  logic [K*K*SUB_W-1:0]   b,
    input  logic                   a_sign,
    input  logic                   b_sign,
    input  logic                   mode,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       result,
    output logic                   overflow
);
    localparam int N  = K*K;
    localparam int OW = N*SUB_W;
    localparam int PW = 2*SUB_W + 2;

    logic                   stall;
    logic                   v1, v2, v3;
    logic [OW-1:0]          a1, b1;
    logic                   as1, bs1, m1, c1, m2, c2, c3;
    logic [N-1:0][PW-1:0]   p, p2;
    logic [N-1:0][ACC_W-1:0] term;
    logic [ACC_W-1:0]       sum, s3, addend, acc_next;
    logic                   add_ovf;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = reset & ~stall;

    // Partial (i,j): mode 0 pairs sub-block i of a with sub-block j of b, mode 1 pairs lane i*K+j of both.
    genvar i, j;
    for (i = 0; i < K; i++) begin : g_row
        for (j = 0; j < K; j++) begin : g_col
            localparam int L = i*K + j;
            logic [SUB_W-1:0]     x, y;
            logic                 sx, sy;
            logic signed [PW-1:0] xe, ye;
            logic [ACC_W-1:0]     ext;
            assign x   = m1 ? a1[L*SUB_W +: SUB_W] : a1[i*SUB_W +: SUB_W];
            assign y   = m1 ? b1[L*SUB_W +: SUB_W] : b1[j*SUB_W +: SUB_W];
            assign sx  = as1 & x[SUB_W-1] & (m1 | (i == K-1));
            assign sy  = bs1 & y[SUB_W-1] & (m1 | (j == K-1));
            assign xe  = PW'($signed({sx, x}));
            assign ye  = PW'($signed({sy, y}));
            assign p[L] = xe * ye;
            assign ext = {{(ACC_W-PW){p2[L][PW-1]}}, p2[L]};
            assign term[L] = m2 ? ext : ext << ((i + j)*SUB_W);
        end
    end

    always_comb begin
        sum = '0;
        for (int n = 0; n < N; n++) sum = sum + term[n];
    end

    assign addend   = c3 ? '0 : result;
    assign acc_next = s3 + addend;
    assign add_ovf  = (s3[ACC_W-1] == addend[ACC_W-1]) & (acc_next[ACC_W-1] != s3[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (!stall) begin
            v1        <= in_valid;
            a1        <= a;
            b1        <= b;
            as1       <= a_sign;
            bs1       <= b_sign;
            m1        <= mode;
            c1        <= acc_clr;
            v2        <= v1;
            p2        <= p;
            m2        <= m1;
            c2        <= c1;
            v3        <= v2;
            s3        <= sum;
            c3        <= c2;
            out_valid <= v3;
            if (v3) begin
                result   <= acc_next;
                overflow <= (overflow & ~c3) | add_ovf;
            end
        end
    end
endmodule

// File: tb/tb_multiplier_sum_mac_pipelined.sv
// tb_multiplier_sum_mac_pipelined: randomized and directed checks of the MAC unit
// against an arithmetic reference model, with a 64-bit and a 56-bit accumulator instance.
module tb_multiplier_sum_mac_pipelined;
    localparam int OW = 81;

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic a_sign = 1'b0, b_sign = 1'b0, mode = 1'b0, acc_clr = 1'b0;
    logic [OW-1:0] a = '0, b = '0;
    logic in_ready, out_valid, overflow, in_ready56, out_valid56, overflow56;
    logic [63:0] result;
    logic [55:0] result56;
    int n_cmp = 0, n_bad = 0, cyc = 0;

    typedef struct {
        logic [63:0] r64;
        logic        o64;
        logic [55:0] r56;
        logic        o56;
        int          cyc;
    } beat_t;
    beat_t exp_q[$], obs_q[$];
    logic signed [127:0] m64 = '0, m56 = '0;
    logic mo64 = 1'b0, mo56 = 1'b0;

    always #5 clk = ~clk;

    multiplier_sum_mac_pipelined dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    multiplier_sum_mac_pipelined #(.ACC_W(56)) dut56 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready56),
        .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid56), .out_ready(out_ready), .result(result56), .overflow(overflow56)
    );

    // Value of one beat as a plain integer: full 27x27 product or sum of nine 9x9 lane products.
    function automatic longint bval(input logic [80:0] av, input logic [80:0] bv,
                                    input logic as, input logic bs, input logic m);
        longint x, y, s;
        s = 0;
        if (!m) begin
            x = longint'(av[26:0]);
            if (as && av[26]) x = x - (longint'(1) <<< 27);
            y = longint'(bv[26:0]);
            if (bs && bv[26]) y = y - (longint'(1) <<< 27);
            s = x * y;
        end else begin
            for (int l = 0; l < 9; l++) begin
                x = longint'(av[l*9 +: 9]);
                if (as && av[l*9+8]) x = x - 512;
                y = longint'(bv[l*9 +: 9]);
                if (bs && bv[l*9+8]) y = y - 512;
                s = s + x * y;
            end
        end
        return s;
    endfunction

    // Exact add, then wrap to w bits; MSB of the return value flags that the exact sum left the w-bit range.
    function automatic logic [128:0] step(input logic signed [127:0] acc, input longint v,
                                          input logic clr, input int w);
        logic signed [127:0] t, lim;
        logic o;
        t   = (clr ? 128'sd0 : acc) + 128'(v);
        lim = 128'sd1 <<< (w - 1);
        o   = (t >= lim) || (t < -lim);
        t   = t <<< (128 - w);
        t   = t >>> (128 - w);
        return {o, t};
    endfunction

    function automatic logic [80:0] rnd81();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[80:0];
    endfunction

    initial begin : monitor
        longint v;
        logic [128:0] st;
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                m64 = '0; m56 = '0; mo64 = 1'b0; mo56 = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    v    = bval(a, b, a_sign, b_sign, mode);
                    st   = step(m64, v, acc_clr, 64);
                    m64  = st[127:0];
                    mo64 = (mo64 & !acc_clr) | st[128];
                    st   = step(m56, v, acc_clr, 56);
                    m56  = st[127:0];
                    mo56 = (mo56 & !acc_clr) | st[128];
                    e.r64 = m64[63:0]; e.o64 = mo64; e.r56 = m56[55:0]; e.o56 = mo56; e.cyc = cyc;
                    exp_q.push_back(e);
                end
                if (out_valid && out_ready) begin
                    e.r64 = result; e.o64 = overflow; e.r56 = result56; e.o56 = overflow56; e.cyc = cyc;
                    obs_q.push_back(e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [80:0] av, input logic [80:0] bv, input logic as,
                        input logic bs, input logic m, input logic c);
        logic ok;
        a = av; b = bv; a_sign = as; b_sign = bs; mode = m; acc_clr = c; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_accept: in_ready stayed 0 for 100 cycles, required 1");
        end
    endtask

    task automatic wait_obs(input int n);
        for (int k = 0; k < 300 && obs_q.size() < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; a = rnd81(); b = rnd81();
        repeat (3) tick();
        n_cmp++;
        if ({out_valid, out_valid56, in_ready, in_ready56, overflow, overflow56} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {out_valid, out_valid56, in_ready, in_ready56, overflow, overflow56});
        end
        n_cmp++;
        if (result !== 64'd0 || result56 !== 56'd0) begin
            n_bad++;
            $display("FAIL reset_result: got %h/%h want 0/0", result, result56);
        end
        in_valid = 1'b0; reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || in_ready56 !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b%b want 11", in_ready, in_ready56);
        end
        tick();
    endtask

    task automatic test_full_mode();
        exp_q.delete(); obs_q.delete();
        send(81'h7FFFFFF, 81'h7FFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: out_valid got %b want 0 two edges after accept", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 64'h003FFFFFF0000001 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL full_unsigned: got v=%b r=%h o=%b want v=1 r=003ffffff0000001 o=0",
                     out_valid, result, overflow);
        end
        send(81'h7FFFFFF, 81'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        send({9{9'h1FF}}, {9{9'h100}}, 1'b1, 1'b1, 1'b1, 1'b1);
        send({9{9'h1FF}}, {9{9'h1FF}}, 1'b0, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_obs(4);
        n_cmp++;
        if (obs_q.size() != 4) begin
            n_bad++;
            $display("FAIL full_count: got %0d results want 4", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[1].r64 !== 64'hFFFFFFFFFFFFFFFB) begin
                n_bad++;
                $display("FAIL full_signed: got %h want fffffffffffffffb", obs_q[1].r64);
            end
            n_cmp++;
            if (obs_q[2].r64 !== 64'd2304) begin
                n_bad++;
                $display("FAIL lanes_signed: got %0d want 2304", obs_q[2].r64);
            end
            n_cmp++;
            if (obs_q[3].r64 !== 64'd2350089) begin
                n_bad++;
                $display("FAIL lanes_unsigned: got %0d want 2350089", obs_q[3].r64);
            end
        end
    endtask

    task automatic test_accumulate();
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 4; k++) send(81'd1000, 81'd1000, 1'b0, 1'b0, 1'b0, k == 0);
        send(81'd2, 81'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_obs(5);
        n_cmp++;
        if (obs_q.size() != 5) begin
            n_bad++;
            $display("FAIL acc_count: got %0d results want 5", obs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (obs_q[k].r64 !== 64'(1000000 * (k + 1)) || obs_q[k].cyc - obs_q[0].cyc != k) begin
                    n_bad++;
                    $display("FAIL acc_beat%0d: got %0d at +%0d want %0d at +%0d", k, obs_q[k].r64,
                             obs_q[k].cyc - obs_q[0].cyc, 1000000 * (k + 1), k);
                end
            end
            n_cmp++;
            if (obs_q[4].r64 !== 64'd6) begin
                n_bad++;
                $display("FAIL acc_clear: got %0d want 6", obs_q[4].r64);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] held;
        exp_q.delete(); obs_q.delete();
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(rnd81(), rnd81(), ($urandom() & 1) != 0, ($urandom() & 1) != 0,
                         ($urandom() & 1) != 0, k == 0);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 50 && !out_valid; k++) tick();
                held = result;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    n_cmp++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== held) begin
                        n_bad++;
                        $display("FAIL stall_hold: got rdy=%b v=%b r=%h want rdy=0 v=1 r=%h",
                                 in_ready, out_valid, result, held);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(6);
        n_cmp++;
        if (obs_q.size() != 6 || exp_q.size() != 6) begin
            n_bad++;
            $display("FAIL stall_count: got %0d results want 6 (accepted %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (obs_q[k].r64 !== exp_q[k].r64 || obs_q[k].o64 !== exp_q[k].o64) begin
                    n_bad++;
                    $display("FAIL stall_beat%0d: got %h/%b want %h/%b", k, obs_q[k].r64, obs_q[k].o64,
                             exp_q[k].r64, exp_q[k].o64);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] ev;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 9; k++) send(81'h4000000, 81'h4000000, 1'b1, 1'b1, 1'b0, k == 0);
        send(81'h4000000, 81'h4000000, 1'b1, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_obs(10);
        n_cmp++;
        if (obs_q.size() != 10) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d results want 10", obs_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                ev = (k == 9) ? (64'd1 << 52) : (64'(k + 1) << 52);
                n_cmp++;
                if (obs_q[k].o56 !== (k == 7 || k == 8) || obs_q[k].r56 !== ev[55:0]) begin
                    n_bad++;
                    $display("FAIL ovf56_beat%0d: got %h/%b want %h/%b", k, obs_q[k].r56, obs_q[k].o56,
                             ev[55:0], (k == 7 || k == 8));
                end
                n_cmp++;
                if (obs_q[k].o64 !== 1'b0 || obs_q[k].r64 !== ev) begin
                    n_bad++;
                    $display("FAIL ovf64_beat%0d: got %h/%b want %h/0", k, obs_q[k].r64, obs_q[k].o64, ev);
                end
            end
        end
    endtask

    task automatic test_reset_mid_group();
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 3; k++) send(81'd100 + 81'(k), 81'd9, 1'b0, 1'b0, 1'b0, k == 0);
        in_valid = 1'b0; reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_in_reset: got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 64'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_state: got v=%b r=%h o=%b want 0/0/0", out_valid, result, overflow);
        end
        reset = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (obs_q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_flush: got %0d stale results want 0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
        send(81'd7, 81'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_obs(1);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0].r64 !== 64'd42) begin
            n_bad++;
            $display("FAIL post_reset_acc: got %0d results first=%0d want 1 result 42", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0].r64 : 64'd0);
        end
    endtask

    task automatic test_random();
        logic done;
        exp_q.delete(); obs_q.delete();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                    send(rnd81(), rnd81(), ($urandom() & 1) != 0, ($urandom() & 1) != 0,
                         ($urandom() & 1) != 0, k == 0 || ($urandom() & 3) == 0);
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom() & 3) != 0;
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(30);
        n_cmp++;
        if (obs_q.size() != 30 || exp_q.size() != 30) begin
            n_bad++;
            $display("FAIL rand_count: got %0d results want 30 (accepted %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < 30; k++) begin
                n_cmp++;
                if ({obs_q[k].r64, obs_q[k].o64, obs_q[k].r56, obs_q[k].o56} !==
                    {exp_q[k].r64, exp_q[k].o64, exp_q[k].r56, exp_q[k].o56}) begin
                    n_bad++;
                    $display("FAIL rand_beat%0d: got %h/%b %h/%b want %h/%b %h/%b", k,
                             obs_q[k].r64, obs_q[k].o64, obs_q[k].r56, obs_q[k].o56,
                             exp_q[k].r64, exp_q[k].o64, exp_q[k].r56, exp_q[k].o56);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_mode();
        test_accumulate();
        test_back_to_back();
        test_overflow();
        test_reset_mid_group();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
